// File: rtl/ysyx_23060072_mem_arbiter.sv
// Shares one data-memory port between IFU (read-only) and LSU (read/write).
// Fixed LSU priority by default; define ARB_ROUND_ROBIN_EN for round-robin arbitration.
module ysyx_23060072_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_rsp_valid,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_rsp_err,

    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [3:0]        lsu_wmask,
    output logic              lsu_rsp_valid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_rsp_err,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic        OWN_IFU  = 1'b0;
    localparam logic        OWN_LSU  = 1'b1;
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t            state, state_nxt;
    logic              owner;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wmask_q;
    logic [15:0]       cnt;

    logic idle, active, lsu_sel, ifu_acc, lsu_acc, acc;
    logic timeout_hit, rsp_ok, abort;

    assign idle   = (state == IDLE);
    assign active = (state == ISSUE) || (state == WAIT);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;

    // On conflict the requester not granted last time wins.
    assign lsu_sel = lsu_req_valid && (!ifu_req_valid || (last_grant == OWN_IFU));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= OWN_IFU;
        else if (acc)
            last_grant <= lsu_acc;
    end
`else
    assign lsu_sel = lsu_req_valid;
`endif

    // Readies are gated by rst_n so they read 0 while reset is held.
    assign lsu_req_ready = rst_n && idle && lsu_sel;
    assign ifu_req_ready = rst_n && idle && ifu_req_valid && !lsu_sel;

    assign lsu_acc = lsu_req_valid && lsu_req_ready;
    assign ifu_acc = ifu_req_valid && ifu_req_ready;
    assign acc     = lsu_acc || ifu_acc;

    assign timeout_hit = active && (cnt == CNT_LAST);
    assign rsp_ok      = (state == WAIT) && mem_rsp_valid;
    // A response arriving in the timeout cycle takes precedence over the abort.
    assign abort       = timeout_hit && !rsp_ok;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (acc) state_nxt = ISSUE;
            ISSUE: begin
                if (timeout_hit)        state_nxt = IDLE;
                else if (mem_req_ready) state_nxt = WAIT;
            end
            WAIT:    if (mem_rsp_valid || timeout_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner   <= OWN_IFU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= 4'h0;
        end else if (acc) begin
            owner   <= lsu_acc;
            addr_q  <= lsu_acc ? lsu_addr : ifu_addr;
            wen_q   <= lsu_acc && lsu_wen;
            wdata_q <= lsu_acc ? lsu_wdata : '0;
            wmask_q <= lsu_acc ? lsu_wmask : 4'hf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (acc)
            cnt <= '0;
        else if (active)
            cnt <= cnt + 16'd1;
    end

    // Response outputs are registered one-cycle pulses; data is 0 outside the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifu_rsp_valid <= 1'b0;
            ifu_rdata     <= '0;
            ifu_rsp_err   <= 1'b0;
            lsu_rsp_valid <= 1'b0;
            lsu_rdata     <= '0;
            lsu_rsp_err   <= 1'b0;
        end else begin
            ifu_rsp_valid <= (rsp_ok || abort) && (owner == OWN_IFU);
            ifu_rdata     <= (rsp_ok && (owner == OWN_IFU)) ? mem_rdata : '0;
            ifu_rsp_err   <= abort && (owner == OWN_IFU);
            lsu_rsp_valid <= (rsp_ok || abort) && (owner == OWN_LSU);
            lsu_rdata     <= (rsp_ok && (owner == OWN_LSU) && !wen_q) ? mem_rdata : '0;
            lsu_rsp_err   <= abort && (owner == OWN_LSU);
        end
    end

    assign mem_req_valid = (state == ISSUE);
    assign mem_addr      = idle ? '0   : addr_q;
    assign mem_wen       = idle ? 1'b0 : wen_q;
    assign mem_wdata     = idle ? '0   : wdata_q;
    assign mem_wmask     = idle ? 4'h0 : wmask_q;
    assign busy          = !idle;

endmodule

// File: tb/tb_ysyx_23060072_mem_arbiter.sv
// Bench for ysyx_23060072_mem_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level reference model.
module tb_ysyx_23060072_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
    logic [AW-1:0] ifu_addr;
    logic [DW-1:0] ifu_rdata;
    logic lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_err;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata, lsu_rdata;
    logic [3:0] lsu_wmask;
    logic mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [3:0] mem_wmask;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ysyx_23060072_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata), .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata), .lsu_rsp_err(lsu_rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string t);
        chk({t, "_irdy"}, ifu_req_ready, 0);
        chk({t, "_lrdy"}, lsu_req_ready, 0);
        chk({t, "_irsp"}, {ifu_rsp_valid, ifu_rsp_err, ifu_rdata}, 0);
        chk({t, "_lrsp"}, {lsu_rsp_valid, lsu_rsp_err, lsu_rdata}, 0);
        chk({t, "_mreq"}, {mem_req_valid, mem_wen, mem_wmask, busy}, 0);
        chk({t, "_maddr"}, mem_addr, 0);
        chk({t, "_mwdata"}, mem_wdata, 0);
    endtask

    task automatic idle_inputs;
        ifu_req_valid = 0; lsu_req_valid = 0; lsu_wen = 0;
        mem_req_ready = 0; mem_rsp_valid = 0;
    endtask

    // ---------------- reference model (one access in flight, abstract age) ----
    bit            m_busy, m_iss, m_own, m_last, m_wen, win_lsu, x_irdy, x_lrdy;
    int            m_age;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [3:0]    m_wmask;
    bit            e_irv, e_ierr, e_lrv, e_lerr;
    logic [DW-1:0] e_ird, e_lrd;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_iss = 0; m_age = 0; m_last = 0;
            e_irv = 0; e_ierr = 0; e_ird = 0; e_lrv = 0; e_lerr = 0; e_lrd = 0;
        end else begin
            if (ifu_req_valid && lsu_req_valid) win_lsu = RR ? (m_last == 0) : 1'b1;
            else win_lsu = lsu_req_valid;
            x_lrdy = !m_busy && lsu_req_valid && win_lsu;
            x_irdy = !m_busy && ifu_req_valid && !win_lsu;
            chk("m_lrdy", lsu_req_ready, x_lrdy);
            chk("m_irdy", ifu_req_ready, x_irdy);
            chk("m_busy", busy, m_busy);
            chk("m_mreqv", mem_req_valid, m_busy && !m_iss);
            chk("m_maddr", mem_addr, m_busy ? m_addr : 0);
            chk("m_mcmd", {mem_wen, mem_wmask}, m_busy ? {m_wen, m_wmask} : 0);
            chk("m_mwdata", mem_wdata, m_busy ? m_wdata : 0);
            chk("m_irsp", {ifu_rsp_valid, ifu_rsp_err}, {e_irv, e_ierr});
            chk("m_irdata", ifu_rdata, e_ird);
            chk("m_lrsp", {lsu_rsp_valid, lsu_rsp_err}, {e_lrv, e_lerr});
            chk("m_lrdata", lsu_rdata, e_lrd);
            e_irv = 0; e_ierr = 0; e_ird = 0; e_lrv = 0; e_lerr = 0; e_lrd = 0;
            if (!m_busy) begin
                if (x_lrdy || x_irdy) begin
                    m_busy = 1; m_iss = 0; m_age = 0; m_own = x_lrdy; m_last = x_lrdy;
                    m_addr  = x_lrdy ? lsu_addr : ifu_addr;
                    m_wen   = x_lrdy && lsu_wen;
                    m_wdata = x_lrdy ? lsu_wdata : 0;
                    m_wmask = x_lrdy ? lsu_wmask : 4'hf;
                end
            end else begin
                m_age++;
                if (m_iss && mem_rsp_valid) begin
                    m_busy = 0;
                    if (m_own) begin e_lrv = 1; e_lrd = m_wen ? 0 : mem_rdata; end
                    else begin e_irv = 1; e_ird = mem_rdata; end
                end else if (m_age == TO) begin
                    m_busy = 0;
                    if (m_own) begin e_lrv = 1; e_lerr = 1; end
                    else begin e_irv = 1; e_ierr = 1; end
                end else if (!m_iss && mem_req_ready) begin
                    m_iss = 1;
                end
            end
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic ifu_read(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cyc; idle_inputs; ifu_req_valid = 1; ifu_addr = a; mem_req_ready = 1;
        @(negedge clk); chk("rd_accept", ifu_req_ready, 1);
        cyc; ifu_req_valid = 0;
        @(negedge clk); chk("rd_mreq", {mem_req_valid, mem_wen, mem_wmask}, 6'b101111);
        chk("rd_maddr", mem_addr, a);
        cyc; mem_rsp_valid = 1; mem_rdata = d;
        cyc; mem_rsp_valid = 0; mem_req_ready = 0;
        @(negedge clk);
        chk("rd_rsp", {ifu_rsp_valid, ifu_rsp_err, lsu_rsp_valid}, 3'b100);
        chk("rd_data", ifu_rdata, d);
    endtask

    int n;
    bit grants[4];
    int rsp_pct;

    initial begin
        idle_inputs; ifu_addr = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0; mem_rdata = 0;
        ifu_req_valid = 1; lsu_req_valid = 1;
        repeat (2) @(posedge clk);
        @(negedge clk); chk_zero("reset");
        cyc; rst_n = 1; idle_inputs;

        // Both requesters valid on every cycle; record who gets the first 4 grants.
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            cyc; ifu_req_valid = 1; lsu_req_valid = 1; ifu_addr = $urandom; lsu_addr = $urandom;
            mem_req_ready = 1; mem_rsp_valid = 1; mem_rdata = $urandom;
            @(negedge clk);
            if (lsu_req_ready) begin grants[n] = 1; n++; end
            else if (ifu_req_ready) begin grants[n] = 0; n++; end
        end
        chk("arb_count", n, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("arb_grant%0d", i), grants[i], RR ? ((i % 2) == 0) : 1'b1);
        cyc; ifu_req_valid = 0; lsu_req_valid = 0;
        repeat (3) cyc;
        idle_inputs;

        ifu_read(32'h8000_0000, 32'hDEAD_BEEF);

        // Store held in ISSUE for 5 cycles while requester inputs wander.
        cyc; idle_inputs; lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_0010;
        lsu_wdata = 32'h1234_5678; lsu_wmask = 4'b0011;
        @(negedge clk); chk("st_accept", lsu_req_ready, 1);
        for (int i = 0; i < 5; i++) begin
            cyc; lsu_req_valid = 0; lsu_wdata = $urandom; lsu_addr = $urandom;
            ifu_req_valid = 1; ifu_addr = $urandom;
            @(negedge clk);
            chk("st_hold_cmd", {mem_req_valid, mem_wen, mem_wmask}, 6'b110011);
            chk("st_hold_addr", mem_addr, 32'h8000_0010);
            chk("st_hold_wdata", mem_wdata, 32'h1234_5678);
            chk("st_hold_rdy", {ifu_req_ready, lsu_req_ready}, 2'b00);
        end
        cyc; ifu_req_valid = 0; mem_req_ready = 1;
        cyc; mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'hFFFF_FFFF;
        cyc; mem_rsp_valid = 0;
        @(negedge clk);
        chk("st_rsp", {lsu_rsp_valid, lsu_rsp_err, ifu_rsp_valid}, 3'b100);
        chk("st_rdata", lsu_rdata, 0);

        // Timeout: memory accepts but never responds.
        cyc; idle_inputs; lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h8000_0100;
        lsu_wmask = 4'b0001; mem_req_ready = 1; mem_rdata = 32'hA5A5_A5A5;
        @(negedge clk); chk("to_accept", lsu_req_ready, 1);
        for (int i = 1; i <= TO; i++) begin
            cyc; lsu_req_valid = 0;
            @(negedge clk); chk("to_pending", lsu_rsp_valid, 0);
        end
        cyc; @(negedge clk);
        chk("to_rsp", {lsu_rsp_valid, lsu_rsp_err}, 2'b11);
        chk("to_rdata", lsu_rdata, 0);
        cyc; cyc; mem_rsp_valid = 1;
        cyc; mem_rsp_valid = 0;
        @(negedge clk); chk("to_late", {lsu_rsp_valid, ifu_rsp_valid}, 2'b00);

        // Async reset during WAIT.
        cyc; idle_inputs; ifu_req_valid = 1; ifu_addr = 32'h8000_0200; mem_req_ready = 1;
        cyc; ifu_req_valid = 0;
        cyc; mem_req_ready = 0;
        @(negedge clk); chk("rst_inwait", {busy, mem_req_valid}, 2'b10);
        #2 rst_n = 0; ifu_req_valid = 1; lsu_req_valid = 1;
        #1 chk_zero("rst_async");
        cyc; cyc; rst_n = 1; idle_inputs; mem_rsp_valid = 1; mem_rdata = 32'h1111_2222;
        cyc; mem_rsp_valid = 0;
        @(negedge clk); chk("rst_stale", {ifu_rsp_valid, lsu_rsp_valid, busy}, 3'b000);
        ifu_read(32'h8000_0300, 32'hCAFE_F00D);

        // Random traffic; response rate varies per chunk to provoke timeouts.
        for (int c = 0; c < 12; c++) begin
            rsp_pct = (c % 3 == 0) ? 5 : 45;
            for (int i = 0; i < 50; i++) begin
                cyc;
                ifu_req_valid = ($urandom_range(99) < 50); ifu_addr = $urandom;
                lsu_req_valid = ($urandom_range(99) < 50); lsu_addr = $urandom;
                lsu_wen = $urandom_range(1); lsu_wdata = $urandom; lsu_wmask = 4'($urandom);
                mem_req_ready = ($urandom_range(99) < 50);
                mem_rsp_valid = ($urandom_range(99) < rsp_pct);
                mem_rdata = $urandom;
            end
        end
        cyc; idle_inputs;
        repeat (12) cyc;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired @%0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
